// File: rtl/dmem_adapter.sv
// Data-memory adapter: turns one pipeline load/store request into a single bus command,
// aligns store lanes, extracts and extends load lanes, and reports misaligned/illegal/timeout errors.
module dmem_adapter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_fcn,
  input  logic [2:0]  req_typ,
  output logic        req_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] M_XRD = 2'd0;
  localparam logic [1:0] M_XWR = 2'd1;
  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_BU = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_HU = 3'd3;
  localparam logic [2:0] MT_W  = 3'd4;
  localparam logic [2:0] MT_WU = 3'd5;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  typ_q;
  logic [7:0]  wait_cnt;

  function automatic logic req_bad(input logic [1:0] fcn, input logic [2:0] typ,
                                   input logic [1:0] a);
    logic bad;
    case (typ)
      MT_B, MT_BU: bad = 1'b0;
      MT_H, MT_HU: bad = a[0];
      MT_W, MT_WU: bad = (a != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad || (fcn != M_XRD && fcn != M_XWR);
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] typ, input logic [1:0] a);
    case (typ)
      MT_B, MT_BU: return 4'b0001 << a;
      MT_H, MT_HU: return a[1] ? 4'b1100 : 4'b0011;
      MT_W, MT_WU: return 4'hF;
      default:     return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] typ, input logic [31:0] d);
    case (typ)
      MT_B, MT_BU: return {4{d[7:0]}};
      MT_H, MT_HU: return {2{d[15:0]}};
      default:     return d;
    endcase
  endfunction

  // Byte/half lanes are picked by the captured low address bits, then extended.
  function automatic logic [31:0] load_ext(input logic [2:0] typ, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = rd[{a, 3'b000} +: 8];
    h_s = a[1] ? rd[31:16] : rd[15:0];
    case (typ)
      MT_B:    return 32'(b_s);
      MT_BU:   return {24'h0, b_s};
      MT_H:    return 32'(h_s);
      MT_HU:   return {16'h0, h_s};
      default: return rd;
    endcase
  endfunction

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      off_q     <= 2'b00;
      typ_q     <= 3'd0;
      wait_cnt  <= 8'd0;
      res_valid <= 1'b0;
      res_data  <= 32'h0;
      res_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 30'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q <= req_addr[1:0];
            typ_q <= req_typ;
            if (req_bad(req_fcn, req_typ, req_addr[1:0])) begin
              state     <= RESP;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= 32'h0;
            end else begin
              state     <= ISSUE;
              bus_valid <= 1'b1;
              bus_we    <= (req_fcn == M_XWR);
              bus_addr  <= req_addr[31:2];
              bus_be    <= lane_be(req_typ, req_addr[1:0]);
              bus_wdata <= (req_fcn == M_XWR) ? lane_wdata(req_typ, req_data) : 32'h0;
            end
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            wait_cnt  <= 8'd0;
            if (bus_we) begin
              state     <= RESP;
              res_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            state     <= RESP;
            res_valid <= 1'b1;
            res_data  <= load_ext(typ_q, off_q, bus_rdata);
          end else if (wait_cnt == TO_LAST) begin
            state     <= RESP;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          res_err   <= 1'b0;
          res_data  <= 32'h0;
          wait_cnt  <= 8'd0;
          bus_we    <= 1'b0;
          bus_addr  <= 30'h0;
          bus_wdata <= 32'h0;
          bus_be    <= 4'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_adapter.md
DMEM_ADAPTER -- requirements
Module: dmem_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in WAIT before a read is aborted with error (range 1..255).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  pipeline memory request valid.
- req_addr  in  32  byte address.
- req_data  in  32  store data, right-aligned.
- req_fcn  in  2  0=M_XRD, 1=M_XWR, 2=M_X.
- req_typ  in  3  0=MT_B, 1=MT_BU, 2=MT_H, 3=MT_HU, 4=MT_W, 5=MT_WU, 6=MT_X.
- req_ready  out  1  adapter can accept a request.
- res_valid  out  1  one-cycle response strobe.
- res_data  out  32  load result, extended; 0 for stores and errors.
- res_err  out  1  qualifies res_valid: misaligned, illegal, or timeout.
- bus_valid  out  1  backend command valid.
- bus_ready  in  1  backend accepts command.
- bus_we  out  1  backend write.
- bus_addr  out  30  word address, req_addr[31:2].
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables; bit i = byte lane i.
- bus_rvalid  in  1  backend read data valid.
- bus_rdata  in  32  backend read word.

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one request outstanding.
REQ-004 req_ready SHALL be 1 exactly when state is IDLE.
REQ-005 In IDLE, req_valid&&req_ready SHALL capture addr, data, fcn, typ into registers.
REQ-006 Captured request SHALL be an error if: fcn=M_X; typ=MT_X or typ=7; half type with addr[0]=1; word type with addr[1:0]!=0.
REQ-007 Error request SHALL go IDLE->RESP with no bus_valid assertion.
REQ-008 Valid request SHALL go IDLE->ISSUE; bus_valid=1 in ISSUE, all bus_* outputs held stable until bus_ready=1.
REQ-009 ISSUE handshake, store: next state RESP; load: next state WAIT.
REQ-010 Store lanes: byte -> be=1<<addr[1:0], wdata={4{data[7:0]}}; half -> be=4'b0011 (addr[1]=0) or 4'b1100, wdata={2{data[15:0]}}; word -> be=4'hF, wdata=data.
REQ-011 Loads SHALL drive bus_we=0 and be per REQ-010 rules.
REQ-012 In WAIT, bus_rvalid=1 SHALL capture the extracted lane: MT_B/MT_H sign-extend, MT_BU/MT_HU zero-extend, MT_W/MT_WU full word; next state RESP.
REQ-013 WAIT counter SHALL clear on entry and increment each cycle without rvalid; at TIMEOUT it SHALL go to RESP with res_err=1, res_data=0.
REQ-014 RESP SHALL assert res_valid for exactly one cycle, then return to IDLE.
REQ-015 bus_rvalid outside WAIT SHALL be ignored, including a late response after timeout.
REQ-016 bus_rvalid in the same cycle as the ISSUE handshake SHALL be ignored; rvalid is sampled only in WAIT.
REQ-017 Latency, request accepted at edge 0: bus_valid in cycle 1. Store with bus_ready=1 in cycle 1 -> res_valid cycle 2. Load with rvalid in cycle k>=2 -> res_valid cycle k+1. Error -> res_valid cycle 1.
REQ-018 All outputs except req_ready SHALL be registered.
REQ-019 bus_valid SHALL be 0 outside ISSUE; bus_addr/wdata/be/we SHALL be 0 in IDLE.

Reset
REQ-020 rst=1 SHALL force state IDLE asynchronously and clear all registers and the WAIT counter.
REQ-021 Reset values: req_ready=1, res_valid=0, res_data=0, res_err=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
REQ-022 Reset in ISSUE/WAIT/RESP SHALL abandon the request with no res_valid; a later bus_rvalid SHALL be ignored.

Verification
REQ-023 Store: addr=0x1002, data=0xAABBCCDD, MT_H -> bus_addr=0x400, be=4'b1100, wdata=0xCCDDCCDD, we=1; res_valid 1 cycle, res_data=0, err=0.
REQ-024 Load: addr=0x2003, MT_B, rdata=0x80000000 -> res_data=0xFFFFFF80; same with MT_BU -> 0x00000080.
REQ-025 Misaligned: addr=0x3001, MT_W, load -> no bus_valid; res_valid cycle 1 with err=1, data=0.
REQ-026 Backpressure: bus_ready low 5 cycles -> bus_valid and bus_* stable, req_ready=0 throughout; completes after bus_ready=1.
REQ-027 Timeout: TIMEOUT=4, no rvalid -> res_valid err=1 data=0; rvalid 3 cycles later -> ignored, state IDLE.
REQ-028 Reset in WAIT, then bus_rvalid=1 -> no res_valid, req_ready=1, all outputs at reset values.
